// File: rtl/board_io_controller.sv
// board_io_controller
// Memory-mapped board I/O block for the single-cycle processor. Owns the
// seven-segment digits, red/green LEDs, push keys and slide switches.
// Inputs are synchronised and debounced. Software polls sticky edge/change
// status registers and clears them by writing 1s.
//
// Ports
//   clk      system clock
//   reset    synchronous reset, active-low
//   addr     byte address from the processor data bus
//   wrEn     write strobe, sampled on rising clk
//   dataIn   write data
//   dataOut  combinational read data, 0 when the block is not selected
//   sel      high while addr lies inside IO_BASE..IO_BASE+0x2C
//   SW       raw slide switches (asynchronous)
//   KEY      raw push keys (asynchronous, 0 = pressed)
//   LEDR     red LEDs
//   LEDG     green LEDs
//   HEX      active-low segments, digit i at [7i+6:7i], order gfedcba
module board_io_controller #(
    parameter int                DBITS           = 32,
    parameter logic [DBITS-1:0]  IO_BASE         = 32'hF0000000,
    parameter int                NUM_SW          = 10,
    parameter int                NUM_KEY         = 4,
    parameter int                NUM_LEDR        = 10,
    parameter int                NUM_LEDG        = 8,
    parameter int                NUM_HEX         = 4,
    parameter int                DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DBITS-1:0]     addr,
    input  logic                 wrEn,
    input  logic [DBITS-1:0]     dataIn,
    output logic [DBITS-1:0]     dataOut,
    output logic                 sel,
    input  logic [NUM_SW-1:0]    SW,
    input  logic [NUM_KEY-1:0]   KEY,
    output logic [NUM_LEDR-1:0]  LEDR,
    output logic [NUM_LEDG-1:0]  LEDG,
    output logic [7*NUM_HEX-1:0] HEX
);

    localparam int NUM_IN = NUM_SW + NUM_KEY;
    localparam int HBITS  = 4 * NUM_HEX;
    localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Key bits sit above the switch bits in the combined input vector.
    localparam logic [NUM_IN-1:0] KEY_MASK = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

    localparam logic [DBITS-1:0] OFF_HEX     = DBITS'(8'h00);
    localparam logic [DBITS-1:0] OFF_LEDR    = DBITS'(8'h04);
    localparam logic [DBITS-1:0] OFF_LEDG    = DBITS'(8'h08);
    localparam logic [DBITS-1:0] OFF_KEYDATA = DBITS'(8'h10);
    localparam logic [DBITS-1:0] OFF_KEYEDGE = DBITS'(8'h14);
    localparam logic [DBITS-1:0] OFF_SWDATA  = DBITS'(8'h20);
    localparam logic [DBITS-1:0] OFF_SWCHG   = DBITS'(8'h24);
    localparam logic [DBITS-1:0] OFF_CTRL    = DBITS'(8'h2C);

    logic [DBITS-1:0]    offset;
    logic                wr;
    logic [NUM_IN-1:0]   sync1, sync2, in_sync;
    logic [NUM_IN-1:0]   deb, deb_update;
    logic [CW-1:0]       cnt [NUM_IN];
    logic [HBITS-1:0]    hex_reg;
    logic [NUM_LEDR-1:0] ledr_reg;
    logic [NUM_LEDG-1:0] ledg_reg;
    logic [1:0]          ctrl_reg;
    logic [NUM_KEY-1:0]  key_edge, key_set, key_clr;
    logic [NUM_SW-1:0]   sw_chg, sw_set, sw_clr;
    logic [7*NUM_HEX-1:0] hex_out;

    // Active-low glyphs for 0-9, A-F.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign offset = addr - IO_BASE;
    assign sel    = (addr >= IO_BASE) && (addr <= IO_BASE + OFF_CTRL);
    assign wr     = wrEn && sel;

    // Two-flop synchroniser. Key flops reset to the raw released level (1),
    // so after the inversion below the keys come out of reset as released and
    // no phantom press is debounced.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= KEY_MASK;
            sync2 <= KEY_MASK;
        end else begin
            sync1 <= {KEY, SW};
            sync2 <= sync1;
        end
    end

    assign in_sync = sync2 ^ KEY_MASK;

    // An input is accepted when it has differed from the debounced value
    // for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        deb_update = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            deb_update[i] = (in_sync[i] != deb[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Any cycle where the input agrees with the debounced value restarts
    // the count, so short glitches are rejected.
    always_ff @(posedge clk) begin
        if (!reset) begin
            deb <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (in_sync[i] != deb[i]) begin
                    if (deb_update[i]) begin
                        deb[i] <= in_sync[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Key edges fire only on presses; switch changes fire in both directions.
    assign key_set = deb_update[NUM_IN-1:NUM_SW] & in_sync[NUM_IN-1:NUM_SW];
    assign sw_set  = deb_update[NUM_SW-1:0];
    assign key_clr = (wr && offset == OFF_KEYEDGE) ? dataIn[NUM_KEY-1:0] : '0;
    assign sw_clr  = (wr && offset == OFF_SWCHG)   ? dataIn[NUM_SW-1:0]  : '0;

    // Software-visible registers. The set term is ORed in after the W1C mask
    // so a status event landing with a clear of the same bit keeps it set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_reg  <= '0;
            ledr_reg <= '0;
            ledg_reg <= '0;
            ctrl_reg <= '0;
            key_edge <= '0;
            sw_chg   <= '0;
        end else begin
            if (wr && offset == OFF_HEX)  hex_reg  <= dataIn[HBITS-1:0];
            if (wr && offset == OFF_LEDR) ledr_reg <= dataIn[NUM_LEDR-1:0];
            if (wr && offset == OFF_LEDG) ledg_reg <= dataIn[NUM_LEDG-1:0];
            if (wr && offset == OFF_CTRL) ctrl_reg <= dataIn[1:0];
            key_edge <= (key_edge & ~key_clr) | key_set;
            sw_chg   <= (sw_chg & ~sw_clr) | sw_set;
        end
    end

    // Registered segment drive, one cycle behind the HEX register or hexBlank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hex_out <= {NUM_HEX{7'h40}};
        end else begin
            for (int i = 0; i < NUM_HEX; i++) begin
                hex_out[7*i +: 7] <= ctrl_reg[0] ? 7'h7F : hex_glyph(hex_reg[4*i +: 4]);
            end
        end
    end

    assign HEX  = hex_out;
    assign LEDR = ctrl_reg[1] ? '1 : ledr_reg;
    assign LEDG = ctrl_reg[1] ? '1 : ledg_reg;

    // Read mux; anything not listed reads 0.
    always_comb begin
        dataOut = '0;
        if (sel) begin
            case (offset)
                OFF_HEX:     dataOut[HBITS-1:0]    = hex_reg;
                OFF_LEDR:    dataOut[NUM_LEDR-1:0] = ledr_reg;
                OFF_LEDG:    dataOut[NUM_LEDG-1:0] = ledg_reg;
                OFF_KEYDATA: dataOut[NUM_KEY-1:0]  = deb[NUM_IN-1:NUM_SW];
                OFF_KEYEDGE: dataOut[NUM_KEY-1:0]  = key_edge;
                OFF_SWDATA:  dataOut[NUM_SW-1:0]   = deb[NUM_SW-1:0];
                OFF_SWCHG:   dataOut[NUM_SW-1:0]   = sw_chg;
                OFF_CTRL:    dataOut[1:0]          = ctrl_reg;
                default:     dataOut               = '0;
            endcase
        end
    end

endmodule
